// File: rtl/clkrstgen_if.sv
// Board-facing and system-facing signals of the clock/reset front end.
// The master side is the generator; the slave side is the board/system.
interface clkrstgen_if;
    logic       BTN_N;
    logic       trap;
    logic       clk;
    logic       clk_en;
    logic       sys_reset;
    logic       btn_pressed;
    logic [1:0] reset_cause;

    modport master (
        input  BTN_N,
        input  trap,
        output clk,
        output clk_en,
        output sys_reset,
        output btn_pressed,
        output reset_cause
    );

    modport slave (
        output BTN_N,
        output trap,
        input  clk,
        input  clk_en,
        input  sys_reset,
        input  btn_pressed,
        input  reset_cause
    );
endinterface

// File: rtl/clkrstgen.sv
// Clock/reset front end: integer clock divider with enable, button debouncer,
// and a stretched system reset that deasserts on a divided-clock boundary.
module clkrstgen #(
    parameter int unsigned DIV        = 4,
    parameter int unsigned DEBOUNCE   = 16,
    parameter int unsigned RESET_HOLD = 8,
    parameter bit          TRAP_RESET = 1'b0
) (
    input  logic        CLK,
    input  logic        power_on_reset,
    clkrstgen_if.master pins
);

    localparam int unsigned CW = $clog2(DIV);
    localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'((DIV + 1) / 2);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        HOLD   = 2'd1,
        RUN    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          div_clk;
    logic          div_en;

    always_comb begin
        cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end

    // clk and clk_en are registered from the next count so they line up
    // exactly with the count value while staying flop-driven.
    always_ff @(posedge CLK or posedge power_on_reset) begin
        if (power_on_reset) begin
            cnt     <= '0;
            div_clk <= 1'b0;
            div_en  <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            div_en  <= (cnt_next == CNT_LAST);
            div_clk <= (cnt_next >= CNT_HIGH);
        end
    end

    // ------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------
    logic          sync1;
    logic          sync2;
    logic          deb_level;
    logic          pressed;
    logic [DW-1:0] deb_cnt;

    always_ff @(posedge CLK or posedge power_on_reset) begin
        if (power_on_reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            deb_level <= 1'b1;
            pressed   <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync1 <= pins.BTN_N;
            sync2 <= sync1;
            if (sync2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= sync2;
                pressed   <= ~sync2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reset sequencer
    // ------------------------------------------------------------------
    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic          sys_rst;
    logic [1:0]    cause;
    logic          trap_fire;

    always_comb begin
        trap_fire = TRAP_RESET && pins.trap && div_en;
    end

    always_ff @(posedge CLK or posedge power_on_reset) begin
        if (power_on_reset) begin
            state    <= ASSERT;
            hold_cnt <= '0;
            sys_rst  <= 1'b1;
            cause    <= 2'd0;
        end else begin
            case (state)
                ASSERT: begin
                    sys_rst <= 1'b1;
                    if (!pressed) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (pressed) begin
                        state <= ASSERT;
                        cause <= 2'd1;
                    end else if (div_en) begin
                        // Leaving on a clk_en edge puts the release on a
                        // divided-clock boundary.
                        if (hold_cnt == HOLD_LAST) begin
                            state   <= RUN;
                            sys_rst <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                RUN: begin
                    if (pressed) begin
                        state   <= ASSERT;
                        sys_rst <= 1'b1;
                        cause   <= 2'd1;
                    end else if (trap_fire) begin
                        state   <= ASSERT;
                        sys_rst <= 1'b1;
                        cause   <= 2'd2;
                    end
                end
                default: begin
                    state   <= ASSERT;
                    sys_rst <= 1'b1;
                end
            endcase
        end
    end

    assign pins.clk         = div_clk;
    assign pins.clk_en      = div_en;
    assign pins.sys_reset   = sys_rst;
    assign pins.btn_pressed = pressed;
    assign pins.reset_cause = cause;

endmodule
